// File: rtl/ula_ctrl.sv
// Sequential front-end for the combinational ULA: accepts a request, drives the ULA,
// waits SETTLE_CYCLES edges, captures and normalizes the result, then hands it out.
module ula_ctrl #(
  parameter int SETTLE_CYCLES = 1,  // legal range 1..15
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_A,
  input  logic [7:0]       req_B,
  input  logic [3:0]       req_Sel,
  output logic [7:0]       ULA_A,
  output logic [7:0]       ULA_B,
  output logic [3:0]       ULA_Sel,
  input  logic [15:0]      ULA_S,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_S,
  output logic [3:0]       rsp_Sel,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       ula_a_q, ula_a_d, ula_b_q, ula_b_d;
  logic [3:0]       ula_sel_q, ula_sel_d;
  logic [15:0]      rsp_s_q, rsp_s_d;
  logic [3:0]       rsp_sel_q, rsp_sel_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [7:0]       err_count_q, err_count_d;

  logic             div_zero, byte_op;
  logic [15:0]      cap_s;

  // Division by zero ignores ULA_S entirely; logic/shift ops only define the low byte.
  assign div_zero = (ula_sel_q == 4'b0011) && (ula_b_q == 8'h00);
  assign byte_op  = (ula_sel_q >= 4'b0100) && (ula_sel_q <= 4'b1101);

  always_comb begin
    cap_s = ULA_S;
    if (div_zero)     cap_s = 16'h0000;
    else if (byte_op) cap_s = {8'h00, ULA_S[7:0]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ula_a_d     = ula_a_q;
    ula_b_d     = ula_b_q;
    ula_sel_d   = ula_sel_q;
    rsp_s_d     = rsp_s_q;
    rsp_sel_d   = rsp_sel_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ula_a_d   = req_A;
          ula_b_d   = req_B;
          ula_sel_d = req_Sel;
          cnt_d     = SETTLE_LD;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_s_d   = cap_s;
          rsp_sel_d = ula_sel_q;
          rsp_err_d = div_zero;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          if (rsp_err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ula_a_q     <= '0;
      ula_b_q     <= '0;
      ula_sel_q   <= '0;
      rsp_s_q     <= '0;
      rsp_sel_q   <= '0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ula_a_q     <= ula_a_d;
      ula_b_q     <= ula_b_d;
      ula_sel_q   <= ula_sel_d;
      rsp_s_q     <= rsp_s_d;
      rsp_sel_q   <= rsp_sel_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign ULA_A     = ula_a_q;
  assign ULA_B     = ula_b_q;
  assign ULA_Sel   = ula_sel_q;
  assign rsp_S     = rsp_s_q;
  assign rsp_Sel   = rsp_sel_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;
  assign err_count = err_count_q;

endmodule
